// File: rtl/core_csr_issue.sv
// core_csr_issue
// CSR access initiator for the RV32I core. Decodes SYSTEM-opcode CSR
// instructions in IDLE, issues one request to the CSR unit, waits for the
// acknowledge (or gives up after TIMEOUT cycles) and writes the old CSR value
// back to rd. The pipeline is stalled while a request is in flight.
//
// Optional feature macro: CSR_RO_TRAP_EN
//   defined   : writes to read-only CSR space (addr[11:10] = 2'b11) are trapped
//               in ERR (illegal_o pulse, no request, no write-back)
//   undefined : such writes are issued normally; illegal_o is tied to 0
//
// Handshake: csr_req_o is high for every cycle spent in REQ, and all request
// fields (addr/op/val/wr) are stable for that whole time. The transfer
// completes in the first REQ cycle where csr_ack_i is high; csr_rdata_i is
// sampled in that same cycle. csr_ack_i in any other state is ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid_i       instr_i valid (only looked at in IDLE)
//   instr_i, rs1_val_i  instruction word and rs1 operand value
//   stall_o             pipeline hold (combinational)
//   csr_req_o .. csr_wr_o  request to the CSR unit
//   csr_ack_i, csr_rdata_i response from the CSR unit
//   rd_we_o, rd_addr_o, rd_data_o  register-file write-back
//   timeout_o           one-cycle pulse: request abandoned
//   illegal_o           one-cycle pulse: trapped read-only CSR write
//   state_dbg           current FSM state (IDLE=0, REQ=1, WB=2, ERR=3)
module core_csr_issue #(
  parameter int XLEN         = 32,
  parameter int CSR_ADDR     = 12,
  parameter int CSR_OP_WIDTH = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid_i,
  input  logic [31:0]             instr_i,
  input  logic [XLEN-1:0]         rs1_val_i,
  output logic                    stall_o,
  output logic                    csr_req_o,
  output logic [CSR_ADDR-1:0]     csr_addr_o,
  output logic [CSR_OP_WIDTH-1:0] csr_op_o,
  output logic [XLEN-1:0]         csr_val_o,
  output logic                    csr_wr_o,
  input  logic                    csr_ack_i,
  input  logic [XLEN-1:0]         csr_rdata_i,
  output logic                    rd_we_o,
  output logic [4:0]              rd_addr_o,
  output logic [XLEN-1:0]         rd_data_o,
  output logic                    timeout_o,
  output logic                    illegal_o,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WB = 2'd2, ERR = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        accept;
  logic        cnt_hit;
  logic [2:0]  op_new;
  logic        wr_new;
  logic [XLEN-1:0] val_new;
  logic        ro_trap;

  // funct3 000 (ECALL/EBREAK) and 100 (reserved) share low bits 00.
  assign accept = (state_q == IDLE) && instr_valid_i &&
                  (instr_i[6:0] == 7'b1110011) && (instr_i[13:12] != 2'b00);

  // 001/010/011 map to themselves; 101/110/111 map to 4/5/6.
  assign op_new = instr_i[14] ? ({1'b0, instr_i[13:12]} + 3'd3)
                              : {1'b0, instr_i[13:12]};

  // Set/clear forms (funct3[1] = 1) with a zero source field only read.
  assign wr_new = !(instr_i[13] && (instr_i[19:15] == 5'd0));

  assign val_new = instr_i[14] ? {{(XLEN-5){1'b0}}, instr_i[19:15]} : rs1_val_i;

`ifdef CSR_RO_TRAP_EN
  assign ro_trap = (instr_i[31:30] == 2'b11) && wr_new;
`else
  assign ro_trap = 1'b0;
`endif

  // The ack is checked before the limit so a late ack still completes.
  assign cnt_hit = (cnt_q == 8'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ro_trap ? ERR : REQ;
      REQ:  if (csr_ack_i || cnt_hit) state_d = WB;
      WB:   state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      csr_addr_o <= '0;
      csr_op_o   <= '0;
      csr_val_o  <= '0;
      csr_wr_o   <= 1'b0;
      rd_addr_o  <= 5'd0;
      rd_data_o  <= '0;
    end else begin
      state_q <= state_d;
      // Counter runs only while in REQ and is zero on every REQ entry.
      cnt_q   <= (state_q == REQ) ? cnt_q + 8'd1 : 8'd0;
      if (accept) begin
        csr_addr_o <= instr_i[31:20];
        csr_op_o   <= CSR_OP_WIDTH'(op_new);
        csr_val_o  <= val_new;
        csr_wr_o   <= wr_new;
        rd_addr_o  <= instr_i[11:7];
      end
      if (state_q == REQ) begin
        if (csr_ack_i)    rd_data_o <= csr_rdata_i;
        else if (cnt_hit) rd_data_o <= '0;
      end
    end
  end

  assign csr_req_o = (state_q == REQ);
  assign rd_we_o   = (state_q == WB) && (rd_addr_o != 5'd0);
  assign timeout_o = (state_q == REQ) && !csr_ack_i && cnt_hit;
  assign stall_o   = accept || (state_q == REQ) || (state_q == ERR);
`ifdef CSR_RO_TRAP_EN
  assign illegal_o = (state_q == ERR);
`else
  assign illegal_o = 1'b0;
`endif
  assign state_dbg = state_q;

endmodule

// File: tb/tb_core_csr_issue.sv
module tb_core_csr_issue;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr_valid_i;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] rs1_val_i;
  logic            stall_o;
  logic            csr_req_o;
  logic [11:0]     csr_addr_o;
  logic [2:0]      csr_op_o;
  logic [XLEN-1:0] csr_val_o;
  logic            csr_wr_o;
  logic            csr_ack_i;
  logic [XLEN-1:0] csr_rdata_i;
  logic            rd_we_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            timeout_o;
  logic            illegal_o;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;

  core_csr_issue dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .rs1_val_i(rs1_val_i), .stall_o(stall_o), .csr_req_o(csr_req_o),
    .csr_addr_o(csr_addr_o), .csr_op_o(csr_op_o), .csr_val_o(csr_val_o),
    .csr_wr_o(csr_wr_o), .csr_ack_i(csr_ack_i), .csr_rdata_i(csr_rdata_i),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .timeout_o(timeout_o), .illegal_o(illegal_o), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] csr_instr(input logic [11:0] csr, input logic [4:0] rs1,
                                            input logic [2:0] f3, input logic [4:0] rd);
    return {csr, rs1, f3, rd, 7'b1110011};
  endfunction

  // One cycle: inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a valid instruction for the current cycle (cycle N).
  task automatic issue(input logic [31:0] ins, input logic [XLEN-1:0] rs1v);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    rs1_val_i     = rs1v;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid_i = 1'b0; instr_i = '0; rs1_val_i = '0;
    csr_ack_i = 1'b0; csr_rdata_i = '0;
    #3;
    checks++; if ({csr_req_o, csr_wr_o, rd_we_o, timeout_o, illegal_o, stall_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000",
                         {csr_req_o, csr_wr_o, rd_we_o, timeout_o, illegal_o, stall_o}); end
    checks++; if ({csr_addr_o, csr_op_o, csr_val_o, rd_addr_o, rd_data_o} !== '0) begin
      errors++; $display("FAIL reset_data got=%0h exp=0",
                         {csr_addr_o, csr_op_o, csr_val_o, rd_addr_o, rd_data_o}); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    // Non-SYSTEM opcode (ADDI-style, funct3 001) must be ignored.
    issue(32'h0000_1013, 32'h1);
    checks++; if (stall_o !== 1'b0) begin
      errors++; $display("FAIL nonsys_stall got=%b exp=0", stall_o); end
    tick(); instr_valid_i = 1'b0;
    checks++; if (csr_req_o !== 1'b0) begin
      errors++; $display("FAIL nonsys_req got=%b exp=0", csr_req_o); end
  endtask

  task automatic test_csrrs_read();
    issue(csr_instr(12'hC00, 5'd0, 3'b010, 5'd5), 32'hDEAD_BEEF);
    checks++; if (stall_o !== 1'b1) begin
      errors++; $display("FAIL rs_stall_n got=%b exp=1", stall_o); end
    tick(); instr_valid_i = 1'b0;   // N+1
    checks++; if ({csr_req_o, csr_op_o, csr_wr_o, csr_addr_o} !== {1'b1, 3'd2, 1'b0, 12'hC00}) begin
      errors++; $display("FAIL rs_req got=%0h exp=%0h", {csr_req_o, csr_op_o, csr_wr_o, csr_addr_o},
                         {1'b1, 3'd2, 1'b0, 12'hC00}); end
    csr_ack_i = 1'b1; csr_rdata_i = 32'h0000_1234;
    tick(); csr_ack_i = 1'b0;       // N+2
    checks++; if ({rd_we_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      errors++; $display("FAIL rs_wb got=%0h exp=%0h", {rd_we_o, rd_addr_o, rd_data_o},
                         {1'b1, 5'd5, 32'h0000_1234}); end
    checks++; if ({stall_o, csr_req_o} !== 2'b00) begin
      errors++; $display("FAIL rs_wb_stall got=%b exp=00", {stall_o, csr_req_o}); end
    tick();                         // N+3
    checks++; if (rd_we_o !== 1'b0) begin
      errors++; $display("FAIL rs_we_once got=%b exp=0", rd_we_o); end
  endtask

  task automatic test_csrrwi_wait();
    issue(csr_instr(12'h340, 5'h1F, 3'b101, 5'd0), 32'h0);
    checks++; if (stall_o !== 1'b1) begin
      errors++; $display("FAIL rwi_stall_n got=%b exp=1", stall_o); end
    for (int k = 1; k <= 4; k++) begin
      tick(); instr_valid_i = 1'b0;
      if (k == 4) begin csr_ack_i = 1'b1; csr_rdata_i = 32'h5555_0000; #1; end
      checks++; if ({csr_req_o, stall_o, csr_wr_o, csr_op_o, csr_val_o, rd_we_o} !==
                    {1'b1, 1'b1, 1'b1, 3'd4, 32'h1F, 1'b0}) begin
        errors++; $display("FAIL rwi_req_%0d got=%0h exp=%0h", k,
          {csr_req_o, stall_o, csr_wr_o, csr_op_o, csr_val_o, rd_we_o},
          {1'b1, 1'b1, 1'b1, 3'd4, 32'h1F, 1'b0}); end
    end
    tick(); csr_ack_i = 1'b0;       // N+5: WB with rd = x0
    checks++; if ({rd_we_o, stall_o, csr_req_o, state_dbg} !== {3'b000, 2'd2}) begin
      errors++; $display("FAIL rwi_wb got=%b exp=00010", {rd_we_o, stall_o, csr_req_o, state_dbg}); end
    tick();
    checks++; if (rd_we_o !== 1'b0) begin
      errors++; $display("FAIL rwi_after got=%b exp=0", rd_we_o); end
  endtask

  task automatic test_timeout();
    issue(csr_instr(12'h300, 5'd7, 3'b011, 5'd3), 32'hFF00_00FF);
    for (int k = 1; k <= 16; k++) begin
      tick(); instr_valid_i = 1'b0;
      checks++; if ({csr_req_o, timeout_o} !== {1'b1, (k == 16)}) begin
        errors++; $display("FAIL to_cycle_%0d got=%b exp=%b", k, {csr_req_o, timeout_o},
                           {1'b1, (k == 16)}); end
      if (k == 1) begin
        checks++; if ({csr_op_o, csr_val_o, csr_wr_o} !== {3'd3, 32'hFF00_00FF, 1'b1}) begin
          errors++; $display("FAIL to_fields got=%0h exp=%0h", {csr_op_o, csr_val_o, csr_wr_o},
                             {3'd3, 32'hFF00_00FF, 1'b1}); end
      end
    end
    tick();                         // N+17
    checks++; if ({rd_we_o, rd_addr_o, rd_data_o, timeout_o, csr_req_o} !== {1'b1, 5'd3, 32'h0, 2'b00}) begin
      errors++; $display("FAIL to_wb got=%0h exp=%0h", {rd_we_o, rd_addr_o, rd_data_o, timeout_o, csr_req_o},
                         {1'b1, 5'd3, 32'h0, 2'b00}); end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    issue(csr_instr(12'h300, 5'd2, 3'b010, 5'd6), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      tick(); instr_valid_i = 1'b0;
    end
    tick();                         // N+16: counter at limit, ack arrives
    csr_ack_i = 1'b1; csr_rdata_i = 32'h0000_A5A5; #1;
    checks++; if ({csr_req_o, timeout_o} !== 2'b10) begin
      errors++; $display("FAIL ack_lim got=%b exp=10", {csr_req_o, timeout_o}); end
    tick(); csr_ack_i = 1'b0;       // N+17
    checks++; if ({rd_we_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd6, 32'h0000_A5A5}) begin
      errors++; $display("FAIL ack_lim_wb got=%0h exp=%0h", {rd_we_o, rd_addr_o, rd_data_o},
                         {1'b1, 5'd6, 32'h0000_A5A5}); end
    tick();
  endtask

  task automatic test_ro_write();
    issue(csr_instr(12'hC00, 5'd1, 3'b001, 5'd2), 32'h77);
    checks++; if (stall_o !== 1'b1) begin
      errors++; $display("FAIL ro_stall_n got=%b exp=1", stall_o); end
    tick(); instr_valid_i = 1'b0;   // N+1
`ifdef CSR_RO_TRAP_EN
    checks++; if ({csr_req_o, illegal_o, stall_o} !== 3'b011) begin
      errors++; $display("FAIL ro_trap got=%b exp=011", {csr_req_o, illegal_o, stall_o}); end
    tick();
    checks++; if ({illegal_o, stall_o, rd_we_o, csr_req_o} !== 4'b0000) begin
      errors++; $display("FAIL ro_after got=%b exp=0000", {illegal_o, stall_o, rd_we_o, csr_req_o}); end
`else
    checks++; if ({csr_req_o, csr_op_o, csr_wr_o, illegal_o, csr_val_o} !== {1'b1, 3'd1, 1'b1, 1'b0, 32'h77}) begin
      errors++; $display("FAIL ro_req got=%0h exp=%0h", {csr_req_o, csr_op_o, csr_wr_o, illegal_o, csr_val_o},
                         {1'b1, 3'd1, 1'b1, 1'b0, 32'h77}); end
    csr_ack_i = 1'b1; csr_rdata_i = 32'h0000_0C0C;
    tick(); csr_ack_i = 1'b0;
    checks++; if ({rd_we_o, rd_addr_o, rd_data_o, illegal_o} !== {1'b1, 5'd2, 32'h0C0C, 1'b0}) begin
      errors++; $display("FAIL ro_wb got=%0h exp=%0h", {rd_we_o, rd_addr_o, rd_data_o, illegal_o},
                         {1'b1, 5'd2, 32'h0C0C, 1'b0}); end
`endif
    tick();
  endtask

  task automatic test_reset_mid_req();
    issue(csr_instr(12'h341, 5'd9, 3'b001, 5'd4), 32'h1234_5678);
    tick(); instr_valid_i = 1'b0;   // N+1
    checks++; if (csr_req_o !== 1'b1) begin
      errors++; $display("FAIL rst_pre_req got=%b exp=1", csr_req_o); end
    rst_n = 1'b0; #1;
    checks++; if ({csr_req_o, stall_o, csr_wr_o, rd_addr_o, csr_addr_o} !== '0) begin
      errors++; $display("FAIL rst_async got=%0h exp=0", {csr_req_o, stall_o, csr_wr_o, rd_addr_o, csr_addr_o}); end
    #1; rst_n = 1'b1;
    csr_ack_i = 1'b1; csr_rdata_i = 32'hBAD0_BAD0;
    tick(); csr_ack_i = 1'b0;
    checks++; if ({rd_we_o, csr_req_o} !== 2'b00) begin
      errors++; $display("FAIL rst_no_wb got=%b exp=00", {rd_we_o, csr_req_o}); end
    issue(32'h0000_0073, 32'h0);    // ECALL
    checks++; if (stall_o !== 1'b0) begin
      errors++; $display("FAIL ecall_stall got=%b exp=0", stall_o); end
    tick(); instr_valid_i = 1'b0;
    checks++; if ({csr_req_o, stall_o, rd_we_o} !== 3'b000) begin
      errors++; $display("FAIL ecall_req got=%b exp=000", {csr_req_o, stall_o, rd_we_o}); end
  endtask

  initial begin
    test_reset();
    test_csrrs_read();
    test_csrrwi_wait();
    test_timeout();
    test_ack_at_timeout();
    test_ro_write();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
